// File: rtl/dmem_mb_if.sv
// Port bundle for the banked dual-port data memory: two access ports plus status.
// Latency: none (wires only); read latency is set by the memory.
// Backpressure: none per port; RDY low means every request is dropped.
interface dmem_mb_if #(
    parameter int AW       = 4,
    parameter int W        = 128,
    parameter int BANK_NUM = 4
);
    logic                CSB1;
    logic                CSB2;
    logic                WEB1;
    logic                WEB2;
    logic [AW-1:0]       A1;
    logic [AW-1:0]       A2;
    logic [BANK_NUM-1:0] BM1;
    logic [BANK_NUM-1:0] BM2;
    logic [W-1:0]        I1;
    logic [W-1:0]        I2;
    logic [W-1:0]        O1;
    logic [W-1:0]        O2;
    logic                OV1;
    logic                OV2;
    logic                RDY;
    logic                INIT_DONE;
    logic                COLL;

    modport master (
        output CSB1, CSB2, WEB1, WEB2, A1, A2, BM1, BM2, I1, I2,
        input  O1, O2, OV1, OV2, RDY, INIT_DONE, COLL
    );

    modport slave (
        input  CSB1, CSB2, WEB1, WEB2, A1, A2, BM1, BM2, I1, I2,
        output O1, O2, OV1, OV2, RDY, INIT_DONE, COLL
    );
endinterface

// File: rtl/dmem_mb.sv
// Multi-bank dual-port data memory with per-bank write masks, post-reset clear engine and write forwarding.
// Latency: write lands at the accepting edge; read data/OV registered RD_LAT-1 edges after the accepting edge.
// Backpressure: none while RDY=1 (one access per port per cycle); all requests are dropped while RDY=0.
module dmem_mb #(
    parameter int DATA_BANK_W  = 32,
    parameter int BANK_NUM     = 4,
    parameter int DEPTH        = 16,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1,
    parameter int FWD          = 1
) (
    input  logic      CLK,
    input  logic      RST,
    dmem_mb_if.slave  bus
);
    localparam int BANK_W = DATA_BANK_W;
    localparam int W      = BANK_NUM * BANK_W;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              r_state;
    logic [AW-1:0]       r_cnt;
    logic                r_rdy;
    logic                r_init_done;
    logic                r_coll;
    logic [W-1:0]        r_o1;
    logic [W-1:0]        r_o2;
    logic                r_ov1;
    logic                r_ov2;
    logic [BANK_W-1:0]   r_mem [BANK_NUM][DEPTH];

    logic                w_wr1;
    logic                w_wr2;
    logic                w_rd1;
    logic                w_rd2;
    logic                w_same;
    logic [W-1:0]        w_rdat1;
    logic [W-1:0]        w_rdat2;

    // Accesses are only honoured once RDY is visible to the requester.
    assign w_wr1  = r_rdy & ~bus.CSB1 & ~bus.WEB1;
    assign w_rd1  = r_rdy & ~bus.CSB1 &  bus.WEB1;
    assign w_wr2  = r_rdy & ~bus.CSB2 & ~bus.WEB2;
    assign w_rd2  = r_rdy & ~bus.CSB2 &  bus.WEB2;
    assign w_same = (bus.A1 == bus.A2);

    // Control FSM: clear sweep, then run; RDY/INIT_DONE follow the state one edge later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
            r_cnt       <= '0;
            r_rdy       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_rdy       <= 1'b1;
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    // Write-write collision flag: both ports hit the same word with overlapping masks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_wr1 & w_wr2 & w_same & (|(bus.BM1 & bus.BM2));
        end
    end

    // Storage array (never reset). Port 2 is written first so port 1 wins on shared banks.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < BANK_NUM; b++) begin
            if (r_state == S_CLEAR && !RST) begin
                r_mem[b][r_cnt] <= '0;
            end else begin
                if (w_wr2 && bus.BM2[b]) begin
                    r_mem[b][bus.A2] <= bus.I2[b*BANK_W +: BANK_W];
                end
                if (w_wr1 && bus.BM1[b]) begin
                    r_mem[b][bus.A1] <= bus.I1[b*BANK_W +: BANK_W];
                end
            end
        end
    end

    // Read word per port; with forwarding, banks written by the other port this cycle show the new data.
    always_comb begin
        w_rdat1 = '0;
        w_rdat2 = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            w_rdat1[b*BANK_W +: BANK_W] = (FWD != 0 && w_wr2 && w_same && bus.BM2[b]) ?
                                          bus.I2[b*BANK_W +: BANK_W] : r_mem[b][bus.A1];
            w_rdat2[b*BANK_W +: BANK_W] = (FWD != 0 && w_wr1 && w_same && bus.BM1[b]) ?
                                          bus.I1[b*BANK_W +: BANK_W] : r_mem[b][bus.A2];
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_lat2
            logic         r_s_v1;
            logic         r_s_v2;
            logic [W-1:0] r_s_d1;
            logic [W-1:0] r_s_d2;

            // Two-stage read: capture at the accepting edge, publish one edge later.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_s_v1 <= 1'b0;
                    r_s_v2 <= 1'b0;
                    r_s_d1 <= '0;
                    r_s_d2 <= '0;
                    r_ov1  <= 1'b0;
                    r_ov2  <= 1'b0;
                    r_o1   <= '0;
                    r_o2   <= '0;
                end else begin
                    r_s_v1 <= w_rd1;
                    r_s_v2 <= w_rd2;
                    if (w_rd1) r_s_d1 <= w_rdat1;
                    if (w_rd2) r_s_d2 <= w_rdat2;
                    r_ov1  <= r_s_v1;
                    r_ov2  <= r_s_v2;
                    if (r_s_v1) r_o1 <= r_s_d1;
                    if (r_s_v2) r_o2 <= r_s_d2;
                end
            end
        end else begin : g_lat1
            // Single-stage read: output register loads at the accepting edge and holds otherwise.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_ov1 <= 1'b0;
                    r_ov2 <= 1'b0;
                    r_o1  <= '0;
                    r_o2  <= '0;
                end else begin
                    r_ov1 <= w_rd1;
                    r_ov2 <= w_rd2;
                    if (w_rd1) r_o1 <= w_rdat1;
                    if (w_rd2) r_o2 <= w_rdat2;
                end
            end
        end
    endgenerate

    assign bus.O1        = r_o1;
    assign bus.O2        = r_o2;
    assign bus.OV1       = r_ov1;
    assign bus.OV2       = r_ov2;
    assign bus.RDY       = r_rdy;
    assign bus.INIT_DONE = r_init_done;
    assign bus.COLL      = r_coll;
endmodule

// File: tb/tb_dmem_mb.sv
// Bench for dmem_mb: two instances (A: RD_LAT=1/clear/forward, B: RD_LAT=2/no clear/no forward)
// share one stimulus stream; a word-level model predicts every output each cycle, and
// directed sequences pin the model with hand-computed literals.
module tb_dmem_mb;
    localparam int BW    = 32;
    localparam int NB    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int W     = BW * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          csb1, csb2, web1, web2;
    logic [AW-1:0] a1, a2;
    logic [NB-1:0] bm1, bm2;
    logic [W-1:0]  i1, i2;

    dmem_mb_if #(.AW(AW), .W(W), .BANK_NUM(NB)) ifa ();
    dmem_mb_if #(.AW(AW), .W(W), .BANK_NUM(NB)) ifb ();

    assign ifa.CSB1 = csb1;  assign ifb.CSB1 = csb1;
    assign ifa.CSB2 = csb2;  assign ifb.CSB2 = csb2;
    assign ifa.WEB1 = web1;  assign ifb.WEB1 = web1;
    assign ifa.WEB2 = web2;  assign ifb.WEB2 = web2;
    assign ifa.A1   = a1;    assign ifb.A1   = a1;
    assign ifa.A2   = a2;    assign ifb.A2   = a2;
    assign ifa.BM1  = bm1;   assign ifb.BM1  = bm1;
    assign ifa.BM2  = bm2;   assign ifb.BM2  = bm2;
    assign ifa.I1   = i1;    assign ifb.I1   = i1;
    assign ifa.I2   = i2;    assign ifb.I2   = i2;

    dmem_mb #(.DATA_BANK_W(BW), .BANK_NUM(NB), .DEPTH(DEPTH), .RD_LAT(1),
              .CLEAR_ON_RST(1), .FWD(1)) u_a (.CLK(clk), .RST(rst), .bus(ifa));
    dmem_mb #(.DATA_BANK_W(BW), .BANK_NUM(NB), .DEPTH(DEPTH), .RD_LAT(2),
              .CLEAR_ON_RST(0), .FWD(0)) u_b (.CLK(clk), .RST(rst), .bus(ifb));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int lat(input int i);  return (i == 0) ? 1 : 2;          endfunction
    function automatic int thr(input int i);  return (i == 0) ? DEPTH + 1 : 1;  endfunction
    function automatic bit fwd(input int i);  return (i == 0);                  endfunction

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                           input logic [NB-1:0] m);
        logic [W-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) if (m[b]) r[b*BW +: BW] = nw[b*BW +: BW];
        return r;
    endfunction

    logic [W-1:0] mem [2][DEPTH];
    int           nrel = 0;
    int           ecnt = 0;
    int           qdue [4][$];
    logic [W-1:0] qdat [4][$];
    logic [W-1:0] hold [4];
    bit           exp_coll [2];

    initial begin : model
        bit m_w1, m_r1, m_w2, m_r2;
        logic [W-1:0] rd;
        for (int k = 0; k < 4; k++) hold[k] = '0;
        forever begin
            @(posedge clk);
            ecnt++;
            if (rst) begin
                nrel = 0;
                for (int k = 0; k < 4; k++) begin
                    qdue[k].delete();
                    qdat[k].delete();
                    hold[k] = '0;
                end
                exp_coll[0] = 1'b0;
                exp_coll[1] = 1'b0;
                for (int k = 0; k < DEPTH; k++) mem[0][k] = '0;
            end else begin
                m_w1 = !csb1 && !web1;  m_r1 = !csb1 && web1;
                m_w2 = !csb2 && !web2;  m_r2 = !csb2 && web2;
                for (int i = 0; i < 2; i++) begin
                    exp_coll[i] = 1'b0;
                    if (nrel >= thr(i)) begin
                        if (m_r1) begin
                            rd = mem[i][a1];
                            if (fwd(i) && m_w2 && a2 == a1) rd = merge(rd, i2, bm2);
                            qdue[i*2].push_back(ecnt + lat(i) - 1);
                            qdat[i*2].push_back(rd);
                        end
                        if (m_r2) begin
                            rd = mem[i][a2];
                            if (fwd(i) && m_w1 && a1 == a2) rd = merge(rd, i1, bm1);
                            qdue[i*2+1].push_back(ecnt + lat(i) - 1);
                            qdat[i*2+1].push_back(rd);
                        end
                        exp_coll[i] = m_w1 && m_w2 && (a1 == a2) && ((bm1 & bm2) != '0);
                        if (m_w2) mem[i][a2] = merge(mem[i][a2], i2, bm2);
                        if (m_w1) mem[i][a1] = merge(mem[i][a1], i1, bm1);
                    end
                end
                nrel++;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin : compare
        bit ev [4];
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 4; k++) begin
                ev[k] = 1'b0;
                if (qdue[k].size() > 0 && qdue[k][0] == ecnt) begin
                    ev[k] = 1'b1;
                    hold[k] = qdat[k].pop_front();
                    void'(qdue[k].pop_front());
                end
            end
            chkb("a_ov1", ifa.OV1, ev[0]);  chk("a_o1", ifa.O1, hold[0]);
            chkb("a_ov2", ifa.OV2, ev[1]);  chk("a_o2", ifa.O2, hold[1]);
            chkb("b_ov1", ifb.OV1, ev[2]);  chk("b_o1", ifb.O1, hold[2]);
            chkb("b_ov2", ifb.OV2, ev[3]);  chk("b_o2", ifb.O2, hold[3]);
            chkb("a_rdy", ifa.RDY, nrel >= thr(0));
            chkb("a_init", ifa.INIT_DONE, nrel >= thr(0));
            chkb("b_rdy", ifb.RDY, nrel >= thr(1));
            chkb("b_init", ifb.INIT_DONE, nrel >= thr(1));
            chkb("a_coll", ifa.COLL, exp_coll[0]);
            chkb("b_coll", ifb.COLL, exp_coll[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        csb1 = 1'b1; web1 = 1'b1; a1 = '0; bm1 = '0; i1 = '0;
        csb2 = 1'b1; web2 = 1'b1; a2 = '0; bm2 = '0; i2 = '0;
    endtask

    task automatic set1(input bit wr, input int ad, input logic [NB-1:0] m, input logic [W-1:0] d);
        csb1 = 1'b0; web1 = !wr; a1 = AW'(ad); bm1 = m; i1 = d;
    endtask

    task automatic set2(input bit wr, input int ad, input logic [NB-1:0] m, input logic [W-1:0] d);
        csb2 = 1'b0; web2 = !wr; a2 = AW'(ad); bm2 = m; i2 = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [W-1:0] initd [DEPTH];
    localparam logic [W-1:0] COLL_WORD = 128'h99999999_55555555_AAAAAAAA_AAAAAAAA;
    localparam logic [W-1:0] PAT1234   = {4{32'h12345678}};

    initial begin : stim
        int seen;
        int ovc;
        idle();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Clear phase of A; B (already running) gets distinct data in every word, A must ignore it.
        seen = 0;
        for (int j = 1; j <= 24; j++) begin
            idle();
            if (j >= 2 && j <= DEPTH + 1) begin
                initd[j-2] = {$urandom(), $urandom(), $urandom(), $urandom()};
                set1(1'b1, j - 2, 4'hF, initd[j-2]);
            end
            step();
            if (seen == 0 && ifa.RDY) seen = j;
        end
        chki("rdy_rise_edge", seen, DEPTH + 1);

        // Read every word on port 2: A must return zeros with one OV per read.
        ovc = 0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            idle();
            if (k < DEPTH) set2(1'b0, k, '0, '0);
            step();
            if (ifa.OV2) begin
                ovc++;
                chk("clear_zero", ifa.O2, '0);
            end
        end
        chki("clear_ov_count", ovc, DEPTH);

        // Masked write over a full word.
        idle(); set1(1'b1, 3, 4'hF, 128'h44444444_33333333_22222222_11111111); step();
        idle(); set1(1'b1, 3, 4'b0101, {4{32'hDDDDDDDD}}); step();
        idle(); set1(1'b0, 3, '0, '0); step();
        chk("mask_word_a", ifa.O1, 128'h44444444_DDDDDDDD_22222222_DDDDDDDD);
        idle(); step();
        chk("mask_word_b", ifb.O1, 128'h44444444_DDDDDDDD_22222222_DDDDDDDD);

        // Write-write collision on address 5.
        idle(); set1(1'b1, 5, 4'hF, {4{32'h99999999}}); step();
        idle();
        set1(1'b1, 5, 4'b0011, {4{32'hAAAAAAAA}});
        set2(1'b1, 5, 4'b0110, {4{32'h55555555}});
        step();
        chkb("coll_pulse", ifa.COLL, 1'b1);
        idle(); step();
        chkb("coll_one_cycle", ifa.COLL, 1'b0);
        chk("model_coll_word", mem[0][5], COLL_WORD);
        set1(1'b0, 5, '0, '0); step();
        chk("coll_word_a", ifa.O1, COLL_WORD);

        // Read-during-write on address 7 from the opposite port.
        idle(); set1(1'b1, 7, 4'hF, '0); step();
        idle(); set1(1'b1, 7, 4'hF, PAT1234); set2(1'b0, 7, '0, '0); step();
        chk("fwd_a", ifa.O2, PAT1234);
        idle(); step();
        chk("nofwd_b", ifb.O2, '0);
        set2(1'b0, 7, '0, '0); step();
        chk("reread_a", ifa.O2, PAT1234);
        idle(); step();
        chk("reread_b", ifb.O2, PAT1234);

        // Back-to-back reads through the two-stage pipeline of B.
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 3) set2(1'b0, k, '0, '0);
            step();
            chkb("lat2_ov", ifb.OV2, (k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) chk("lat2_data", ifb.O2, initd[k-1]);
        end

        // Random traffic on a small address window to provoke collisions and forwarding.
        for (int n = 0; n < 600; n++) begin
            csb1 = 1'($urandom_range(0, 3) == 0);
            web1 = 1'($urandom_range(0, 1));
            a1   = AW'($urandom_range(0, 3));
            bm1  = NB'($urandom_range(0, 15));
            i1   = {$urandom(), $urandom(), $urandom(), $urandom()};
            csb2 = 1'($urandom_range(0, 3) == 0);
            web2 = 1'($urandom_range(0, 1));
            a2   = AW'($urandom_range(0, 3));
            bm2  = NB'($urandom_range(0, 15));
            i2   = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end

        // Reset while a read is in flight on B, then again partway through A's clear.
        idle(); set2(1'b0, 7, '0, '0); step();
        rst = 1'b1;
        #1;
        chk("rst_async_o2_a", ifa.O2, '0);
        chkb("rst_async_rdy_b", ifb.RDY, 1'b0);
        idle();
        step(); step();
        rst = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        #1;
        chkb("midclear_rdy", ifa.RDY, 1'b0);
        chkb("midclear_init", ifa.INIT_DONE, 1'b0);
        chkb("midclear_ov2", ifa.OV2, 1'b0);
        step(); step();
        rst = 1'b0;
        seen = 0;
        for (int j = 1; j <= 24; j++) begin
            step();
            if (seen == 0 && ifa.RDY) seen = j;
        end
        chki("rdy_rise_after_restart", seen, DEPTH + 1);

        // A was cleared again; B's array kept its contents across reset.
        idle(); set1(1'b0, 5, '0, '0); step();
        chkb("post_clear_ov_a", ifa.OV1, 1'b1);
        chk("post_clear_a", ifa.O1, '0);
        idle(); step();
        chk("keep_b", ifb.O1, COLL_WORD);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
